// File: rtl/lcd_sprite_engine.sv
// lcd_sprite_engine
// Drives a PCD8544-class LCD through spi_master. It runs the power-up command
// sequence and clears the panel, then draws on request either a ROM sprite
// (SPRITE_W columns) or a level bar (BAR_MAX segments of 3 columns) at any
// column/bank, with optional inversion of the data bytes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start_init or a draw request
// INIT    | sending 0x21, VOP, 0x20, 0x0C as commands
// CLEAR   | sending LCD_COLS*LCD_BANKS zero data bytes
// SET_X   | sending column address command 0x80|x
// SET_Y   | sending bank address command 0x40|bank
// DATA    | sending W data bytes (sprite or bar)
// FIN     | one cycle: done pulse, byte stream stopped
//
// Ports:
//   clock, Reset            system clock, synchronous active-low reset
//   start_init              pulse: run init + clear
//   req_valid/req_ready     draw request handshake
//   req_mode                0 = sprite, 1 = bar
//   req_sprite, req_level   sprite index / bar level
//   req_x, req_bank         start column / bank
//   req_invert              XOR 0xFF onto data bytes
//   rom_addr, rom_data      sprite ROM, 1-cycle read latency
//   spi_data, spi_dc        byte to spi_master and its command/data flag
//   spi_start, spi_avail    byte stream active / current byte consumed
//   inited, busy, done, err status
module lcd_sprite_engine #(
    parameter int          SPRITE_W  = 8,
    parameter int          N_SPRITES = 8,
    parameter int          ROM_AW    = 6,
    parameter int          LCD_COLS  = 84,
    parameter int          LCD_BANKS = 6,
    parameter logic [7:0]  VOP       = 8'h90,
    parameter int          BAR_MAX   = 8
) (
    input  logic                          clock,
    input  logic                          Reset,
    input  logic                          start_init,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_mode,
    input  logic [$clog2(N_SPRITES)-1:0]  req_sprite,
    input  logic [3:0]                    req_level,
    input  logic [6:0]                    req_x,
    input  logic [2:0]                    req_bank,
    input  logic                          req_invert,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [7:0]                    rom_data,
    output logic [7:0]                    spi_data,
    output logic                          spi_dc,
    output logic                          spi_start,
    input  logic                          spi_avail,
    output logic                          inited,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int CLR_N = LCD_COLS * LCD_BANKS;
    localparam int CLR_W = $clog2(CLR_N + 1);
    localparam int BAR_W = 3 * BAR_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CLEAR, S_SET_X, S_SET_Y, S_DATA, S_FIN
    } state_t;

    state_t           state;
    logic [1:0]       init_idx;
    logic [CLR_W-1:0] clr_cnt;
    logic [7:0]       col;
    logic [7:0]       seg;
    logic [1:0]       pos;
    logic             mode;
    logic             inv;
    logic [3:0]       lvl;
    logic [6:0]       x_q;
    logic [2:0]       bank_q;

    int               req_w;
    logic             req_bad;
    logic [3:0]       req_lvl_clamped;
    logic [7:0]       last_col;
    logic [7:0]       nseg;
    logic [1:0]       npos;

    // One bar segment is two lit columns followed by a gap column.
    function automatic logic [7:0] bar_byte(input logic [7:0] s, input logic [1:0] p,
                                            input logic [3:0] l);
        return ((s < {4'b0, l}) && (p != 2'd2)) ? 8'h7E : 8'h00;
    endfunction

    assign req_ready = (state == S_IDLE) && inited && !start_init;

    always_comb begin
        req_w   = req_mode ? BAR_W : SPRITE_W;
        req_bad = ((int'(req_x) + req_w) > LCD_COLS)
               || (int'(req_bank) >= LCD_BANKS)
               || (!req_mode && (int'(req_sprite) >= N_SPRITES));
        req_lvl_clamped = (int'(req_level) > BAR_MAX) ? 4'(BAR_MAX) : req_level;
        last_col = mode ? 8'(BAR_W - 1) : 8'(SPRITE_W - 1);
        if (pos == 2'd2) begin
            nseg = seg + 8'd1;
            npos = 2'd0;
        end else begin
            nseg = seg;
            npos = pos + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state     <= S_IDLE;
            init_idx  <= '0;
            clr_cnt   <= '0;
            col       <= '0;
            seg       <= '0;
            pos       <= '0;
            mode      <= 1'b0;
            inv       <= 1'b0;
            lvl       <= '0;
            x_q       <= '0;
            bank_q    <= '0;
            rom_addr  <= '0;
            spi_data  <= '0;
            spi_dc    <= 1'b0;
            spi_start <= 1'b0;
            inited    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    spi_start <= 1'b0;
                    busy      <= 1'b0;
                    if (start_init) begin
                        state     <= S_INIT;
                        init_idx  <= '0;
                        spi_data  <= 8'h21;
                        spi_dc    <= 1'b0;
                        spi_start <= 1'b1;
                        busy      <= 1'b1;
                        inited    <= 1'b0;
                    end else if (req_valid && inited) begin
                        if (req_bad) begin
                            err <= 1'b1;
                        end else begin
                            mode      <= req_mode;
                            inv       <= req_invert;
                            lvl       <= req_lvl_clamped;
                            x_q       <= req_x;
                            bank_q    <= req_bank;
                            // Issue the first sprite address now so rom_data is
                            // settled long before the SET_Y byte is consumed.
                            rom_addr  <= ROM_AW'(req_sprite) * ROM_AW'(SPRITE_W);
                            state     <= S_SET_X;
                            spi_data  <= {1'b1, req_x};
                            spi_dc    <= 1'b0;
                            spi_start <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (spi_avail) begin
                        init_idx <= init_idx + 2'd1;
                        case (init_idx)
                            2'd0: spi_data <= VOP;
                            2'd1: spi_data <= 8'h20;
                            2'd2: spi_data <= 8'h0C;
                            default: begin
                                state    <= S_CLEAR;
                                spi_data <= 8'h00;
                                spi_dc   <= 1'b1;
                                clr_cnt  <= '0;
                            end
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (spi_avail) begin
                        if (clr_cnt == CLR_W'(CLR_N - 1)) begin
                            state     <= S_FIN;
                            spi_start <= 1'b0;
                            done      <= 1'b1;
                            inited    <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                S_SET_X: begin
                    if (spi_avail) begin
                        state    <= S_SET_Y;
                        spi_data <= 8'h40 | {5'b0, bank_q};
                    end
                end
                S_SET_Y: begin
                    if (spi_avail) begin
                        state  <= S_DATA;
                        col    <= '0;
                        seg    <= '0;
                        pos    <= '0;
                        spi_dc <= 1'b1;
                        if (mode) begin
                            spi_data <= bar_byte(8'd0, 2'd0, lvl) ^ {8{inv}};
                        end else begin
                            spi_data <= rom_data ^ {8{inv}};
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (spi_avail) begin
                        if (col == last_col) begin
                            state     <= S_FIN;
                            spi_start <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            col <= col + 8'd1;
                            if (mode) begin
                                seg      <= nseg;
                                pos      <= npos;
                                spi_data <= bar_byte(nseg, npos, lvl) ^ {8{inv}};
                            end else begin
                                // rom_data already holds the byte for col+1;
                                // request col+2 for the next avail.
                                spi_data <= rom_data ^ {8{inv}};
                                rom_addr <= rom_addr + 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    spi_start <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_sprite_engine.sv
module tb_lcd_sprite_engine;

    logic       clock = 1'b0;
    logic       Reset = 1'b0;
    logic       start_init = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_mode = 1'b0;
    logic [2:0] req_sprite = '0;
    logic [3:0] req_level = '0;
    logic [6:0] req_x = '0;
    logic [2:0] req_bank = '0;
    logic       req_invert = 1'b0;
    logic [5:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic [7:0] spi_data;
    logic       spi_dc;
    logic       spi_start;
    logic       spi_avail = 1'b0;
    logic       inited, busy, done, err;

    logic [7:0] rom [0:63];
    logic [9:0] q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    lcd_sprite_engine dut (
        .clock(clock), .Reset(Reset), .start_init(start_init),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_sprite(req_sprite), .req_level(req_level), .req_x(req_x),
        .req_bank(req_bank), .req_invert(req_invert), .rom_addr(rom_addr),
        .rom_data(rom_data), .spi_data(spi_data), .spi_dc(spi_dc),
        .spi_start(spi_start), .spi_avail(spi_avail), .inited(inited),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic dc, input logic [7:0] d);
        q.push_back({1'b0, dc, d});
    endtask

    task automatic push_init();
        push(1'b0, 8'h21); push(1'b0, 8'h90); push(1'b0, 8'h20); push(1'b0, 8'h0C);
        for (int i = 0; i < 504; i++) push(1'b1, 8'h00);
    endtask

    task automatic push_sprite(input int s, input int x, input int bank, input logic inv);
        push(1'b0, 8'h80 | 8'(x));
        push(1'b0, 8'h40 | 8'(bank));
        for (int c = 0; c < 8; c++) push(1'b1, rom[s * 8 + c] ^ {8{inv}});
    endtask

    task automatic push_bar(input int level, input int x, input int bank, input logic inv);
        int l;
        logic [7:0] b;
        l = (level > 8) ? 8 : level;
        push(1'b0, 8'h80 | 8'(x));
        push(1'b0, 8'h40 | 8'(bank));
        for (int c = 0; c < 24; c++) begin
            b = ((c / 3) < l && (c % 3) != 2) ? 8'h7E : 8'h00;
            push(1'b1, b ^ {8{inv}});
        end
    endtask

    // Consumes n bytes with avail every 4 cycles; the byte on the bus at each
    // avail is compared against the scoreboard head.
    task automatic consume(input int n, input string tag);
        logic [9:0] e;
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge clock);
            check({tag, "_start"}, spi_start, 1);
            e = (q.size() > 0) ? q.pop_front() : 10'h3FF;
            check(tag, {1'b0, spi_dc, spi_data}, e);
            spi_avail = 1'b1;
            @(negedge clock);
            spi_avail = 1'b0;
        end
    endtask

    task automatic finish_op(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_fin_start"}, spi_start, 0);
        check({tag, "_fin_busy"}, busy, 1);
        @(negedge clock);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic send_req(input logic m, input int s, input int lvl, input int x,
                            input int bank, input logic inv, input logic exp_ready,
                            input string tag);
        req_mode = m; req_sprite = 3'(s); req_level = 4'(lvl); req_x = 7'(x);
        req_bank = 3'(bank); req_invert = inv; req_valid = 1'b1;
        #1;
        check({tag, "_ready"}, req_ready, exp_ready);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic reject(input logic m, input int s, input int x, input int bank,
                          input string tag);
        send_req(m, s, 0, x, bank, 1'b0, 1'b1, tag);
        check({tag, "_err"}, err, 1);
        check({tag, "_start"}, spi_start, 0);
        check({tag, "_busy"}, busy, 0);
        @(negedge clock);
        check({tag, "_err_clr"}, err, 0);
        repeat (3) @(negedge clock);
        check({tag, "_nostart"}, spi_start, 0);
    endtask

    task automatic pulse_init();
        start_init = 1'b1;
        @(negedge clock);
        start_init = 1'b0;
    endtask

    initial begin
        int done_seen;
        for (int i = 0; i < 64; i++) rom[i] = 8'(i * 7 + 3);
        for (int k = 0; k < 8; k++) rom[16 + k] = 8'(k + 1);

        // Reset held two cycles
        repeat (2) @(negedge clock);
        check("rst_start", spi_start, 0);
        check("rst_busy", busy, 0);
        check("rst_inited", inited, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data", spi_data, 0);
        check("rst_dc", spi_dc, 0);
        check("rst_addr", rom_addr, 0);
        Reset = 1'b1;
        @(negedge clock);

        // Request before init is never accepted
        req_mode = 1'b0; req_sprite = 3'd1; req_x = 7'd0; req_bank = 3'd0;
        req_valid = 1'b1;
        #1;
        check("preinit_ready", req_ready, 0);
        repeat (4) @(negedge clock);
        check("preinit_start", spi_start, 0);
        check("preinit_busy", busy, 0);
        req_valid = 1'b0;

        // Init + clear
        push_init();
        pulse_init();
        check("init_busy", busy, 1);
        consume(508, "init");
        finish_op("init");
        check("init_inited", inited, 1);
        check("init_q", q.size(), 0);

        // Sprite 2 at x=10 bank 3, then an immediate bar after FIN
        push_sprite(2, 10, 3, 1'b0);
        send_req(1'b0, 2, 0, 10, 3, 1'b0, 1'b1, "spr");
        consume(10, "spr");
        check("spr_fin_ready", req_ready, 0);
        finish_op("spr");

        push_bar(2, 9, 0, 1'b1);
        send_req(1'b1, 0, 2, 9, 0, 1'b1, 1'b1, "bar2");
        consume(26, "bar2");
        finish_op("bar2");

        // Level 12 clamps to 8; bar ending exactly at the last column
        push_bar(12, 60, 5, 1'b0);
        send_req(1'b1, 0, 12, 60, 5, 1'b0, 1'b1, "bar12");
        consume(26, "bar12");
        finish_op("bar12");

        // Inverted sprite 7 ending exactly at column 83, level-0 bar
        push_sprite(7, 76, 2, 1'b1);
        send_req(1'b0, 7, 0, 76, 2, 1'b1, 1'b1, "spr7");
        consume(10, "spr7");
        finish_op("spr7");

        push_bar(0, 0, 1, 1'b0);
        send_req(1'b1, 0, 0, 0, 1, 1'b0, 1'b1, "bar0");
        consume(26, "bar0");
        finish_op("bar0");

        // Rejects
        reject(1'b0, 0, 80, 0, "rej_x");
        reject(1'b0, 0, 0, 6, "rej_bank");
        reject(1'b1, 0, 61, 0, "rej_barx");

        // start_init wins over a simultaneous request
        push_init();
        req_mode = 1'b0; req_sprite = 3'd2; req_x = 7'd10; req_bank = 3'd3;
        req_valid = 1'b1; start_init = 1'b1;
        #1;
        check("both_ready", req_ready, 0);
        @(negedge clock);
        req_valid = 1'b0; start_init = 1'b0;
        check("both_inited", inited, 0);
        consume(508, "reinit");
        finish_op("reinit");
        check("reinit_inited", inited, 1);

        // Reset while byte 4 of a sprite is on the bus
        push_sprite(2, 20, 1, 1'b0);
        send_req(1'b0, 2, 0, 20, 1, 1'b0, 1'b1, "abort");
        consume(6, "abort");
        Reset = 1'b0;
        @(negedge clock);
        Reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_start", spi_start, 0);
        check("abort_inited", inited, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_seen++;
            @(negedge clock);
        end
        check("abort_nodone", done_seen, 0);
        q.delete();

        push_init();
        pulse_init();
        consume(508, "init3");
        finish_op("init3");
        check("init3_inited", inited, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
